counter_seq_ctrl: RTL
=====================

Name: counter_seq_ctrl

Overview:
- Sequencer for a cascaded up-counter built from 4-bit loadable counter slices (8-bit default: two slices).
- Loads a start value and issues prescaled count-enable ticks with correct carry gating between slices.
- Detects terminal count (all ones) and either stops (one-shot) or reloads (periodic), reporting done pulses and a reload tally.
- Sits between the host/control logic and the counter slice datapath; the slices themselves are unchanged.

Parameters:
- NSLICE, 2, number of 4-bit counter slices; counter width is W = 4*NSLICE.
- DIV, 1, prescaler ratio; one count tick every DIV clocks; legal range 1..256.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled in IDLE only.
- stop  in  1  abort a run; sampled in LOAD/COUNT.
- mode  in  1  0 = one-shot, 1 = auto-reload; latched on start.
- init_val  in  W  start value; latched on start.
- co_in  in  NSLICE  carry-out (slice == 4'hF) from each slice, bit i = slice i, slice 0 = LSB.
- ld  out  1  parallel-load strobe, broadcast to all slices.
- par_out  out  W  load value to slices; nibble i drives slice i.
- cen  out  NSLICE  count enable per slice.
- busy  out  1  high in LOAD and COUNT.
- done  out  1  one-cycle pulse per terminal count.
- reload_cnt  out  8  number of reloads since start; saturates at 255.

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE; ld = 0; cen = 0; par_out = 0; busy = 0; done = 0; reload_cnt = 0; prescaler = 0.
  - Applies immediately, including mid-run.
- States: IDLE, LOAD, COUNT, DONE (2-bit encoding).
- IDLE:
  - start=1 latches init_val into par_out, latches mode, clears reload_cnt, and moves to LOAD.
  - stop is ignored.
- LOAD (exactly 1 cycle):
  - ld = 1, cen = 0, prescaler cleared, next state COUNT.
  - stop=1 goes to IDLE with ld still asserted this cycle.
- COUNT:
  - The prescaler counts 0..DIV-1 and wraps; tick = (prescaler == DIV-1). With DIV = 1, tick is high every cycle.
  - cen[0] = tick.
  - cen[i] = tick AND co_in[0] AND ... AND co_in[i-1].
  - Terminal = tick AND (all co_in bits = 1).
  - Terminal, mode=0: cen forced to 0 (counter holds all-ones), next state DONE.
  - Terminal, mode=1: cen forced to 0 and ld = 1 (reload init value in that same cycle), done = 1 next cycle, reload_cnt += 1 (saturating), prescaler restarts from 0, stay in COUNT.
  - stop=1 has priority over terminal: cen = 0 and ld = 0 that cycle, next state IDLE. The counter holds its value and no done pulse is produced.
  - start is ignored.
- DONE (1 cycle):
  - done = 1, busy = 0, next state IDLE.
  - start in DONE is ignored; it is accepted from IDLE one cycle later.
- Output timing:
  - ld and cen are combinational from state, prescaler and co_in.
  - done, busy and par_out are registered.
- Boundary cases:
  - init_val = all ones: the first tick is terminal.
  - init_val = 0: the run takes 2^W ticks to reach terminal.
  - cen never asserts in IDLE, LOAD or DONE.
  - ld and cen are never high in the same cycle.

Test Plan:
1. NSLICE=2, DIV=1, mode=0, init_val=8'hFA, start at cycle 0 -> ld high at cycle 1; cen[0] high at cycles 2..6; counter reaches 8'hFF at cycle 7; terminal at cycle 7 with cen=0; done pulse at cycle 8; busy low from cycle 8; counter holds 8'hFF.
2. DIV=1, mode=1, init_val=8'hFE -> counter sequence FE, FF, FE, FF, ...; ld asserted on each FF cycle; done pulses every 2 cycles; reload_cnt reads 1, 2, 3, ... and stops at 255 after 255 reloads.
3. DIV=4, mode=0, init_val=8'h0E -> cen[0] high only on every 4th COUNT cycle; the tick taking 0F->10 also asserts cen[1]; cen[1] is low on all other ticks; after 2 ticks the counter reads 8'h10.
4. DIV=1, mode=1, init_val=8'h00; assert stop when the counter reads 8'h37 -> next state IDLE; cen=0 from that cycle; counter holds 8'h37; no done pulse; a following start is accepted.
5. Pull rst low mid-COUNT (asynchronous, between clock edges) -> ld, cen, busy, done and reload_cnt go to 0 immediately; the block stays in IDLE until start after rst is released.
6. Pulse start while busy, and during DONE -> no reload of init_val and no state change; start pulsed from IDLE one cycle later -> LOAD follows.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
// Sequencer for a cascaded up-counter built from 4-bit loadable slices.
// It loads a start value into the slices and issues prescaled count ticks.
// Each tick is gated by the carry-outs of the lower slices. At terminal
// count (all ones) it either stops (one-shot) or reloads (auto-reload).
// It reports a done pulse per terminal count and a saturating reload tally.
// ld and cen are combinational so the slices act on them in the same
// cycle. done, busy, par_out and reload_cnt are registered.
module counter_seq_ctrl #(
    parameter int NSLICE = 2,
    parameter int DIV    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [4*NSLICE-1:0]   init_val,
    input  logic [NSLICE-1:0]     co_in,
    output logic                  ld,
    output logic [4*NSLICE-1:0]   par_out,
    output logic [NSLICE-1:0]     cen,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            reload_cnt
);

    localparam int W = 4 * NSLICE;

    // Last prescaler value. DIV is limited to 1..256, so 8 bits always suffice.
    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_COUNT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [7:0]        presc_r;
    logic [7:0]        presc_nxt_s;
    logic              mode_r;
    logic [W-1:0]      par_r;
    logic              busy_r;
    logic              done_r;
    logic [7:0]        reload_r;

    logic              tick_s;
    logic              all_co_s;
    logic              terminal_s;
    logic [NSLICE-1:0] carry_s;
    logic              ld_s;
    logic [NSLICE-1:0] cen_s;
    logic              start_acc_s;
    logic              reload_evt_s;
    logic              done_evt_s;
    logic              busy_nxt_s;

    // Saturating increment for the 8-bit reload tally.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        logic [7:0] res;
        if (val == 8'hFF) begin
            res = 8'hFF;
        end else begin
            res = val + 8'd1;
        end
        return res;
    endfunction

    // Carry gating: slice i may count only when every lower slice is at 4'hF.
    always_comb begin : carry_chain
        logic acc_v;
        acc_v   = 1'b1;
        carry_s = {NSLICE{1'b0}};
        for (int i = 0; i < NSLICE; i++) begin
            carry_s[i] = acc_v;
            acc_v      = acc_v & co_in[i];
        end
    end

    assign all_co_s   = &co_in;
    assign tick_s     = (presc_r == DIV_LAST);
    assign terminal_s = tick_s & all_co_s;

    // Next-state logic with the combinational load/enable strobes and run events.
    always_comb begin
        state_nxt_s  = state_r;
        presc_nxt_s  = presc_r;
        ld_s         = 1'b0;
        cen_s        = {NSLICE{1'b0}};
        start_acc_s  = 1'b0;
        reload_evt_s = 1'b0;
        done_evt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                presc_nxt_s = 8'd0;
                if (start) begin
                    start_acc_s = 1'b1;
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                // The load strobe is issued even when the run is being aborted.
                ld_s        = 1'b1;
                presc_nxt_s = 8'd0;
                if (stop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (stop) begin
                    // Abort wins over terminal: the slices simply hold their value.
                    presc_nxt_s = 8'd0;
                    state_nxt_s = ST_IDLE;
                end else if (terminal_s) begin
                    presc_nxt_s = 8'd0;
                    done_evt_s  = 1'b1;
                    if (mode_r) begin
                        // Reload the start value in the terminal cycle itself.
                        ld_s         = 1'b1;
                        reload_evt_s = 1'b1;
                        state_nxt_s  = ST_COUNT;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else begin
                    cen_s = carry_s & {NSLICE{tick_s}};
                    if (tick_s) begin
                        presc_nxt_s = 8'd0;
                    end else begin
                        presc_nxt_s = presc_r + 8'd1;
                    end
                    state_nxt_s = ST_COUNT;
                end
            end
            ST_DONE: begin
                presc_nxt_s = 8'd0;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                presc_nxt_s = 8'd0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign busy_nxt_s = (state_nxt_s == ST_LOAD) || (state_nxt_s == ST_COUNT);

    // State and prescaler registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            presc_r <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            presc_r <= presc_nxt_s;
        end
    end

    // Run parameters, latched only when a start is accepted from IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_r  <= {W{1'b0}};
            mode_r <= 1'b0;
        end else if (start_acc_s) begin
            par_r  <= init_val;
            mode_r <= mode;
        end else begin
            par_r  <= par_r;
            mode_r <= mode_r;
        end
    end

    // Registered status: busy tracks LOAD/COUNT; done follows a terminal count by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_nxt_s;
            done_r <= done_evt_s;
        end
    end

    // Reload tally: cleared on each accepted start, saturating at 255.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload_r <= 8'd0;
        end else if (start_acc_s) begin
            reload_r <= 8'd0;
        end else if (reload_evt_s) begin
            reload_r <= sat_inc8(reload_r);
        end else begin
            reload_r <= reload_r;
        end
    end

    assign ld         = ld_s;
    assign cen        = cen_s;
    assign par_out    = par_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign reload_cnt = reload_r;

endmodule
